// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered 3-to-8 one-hot select with load and auto-scan sequencing
module onehot_scan_decoder #(
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       scan,
    input  logic       load,
    input  logic [2:0] in,
    output logic [7:0] out,
    output logic [2:0] idx,
    output logic       wrap
);
    localparam logic [15:0] LAST = 16'(DIV - 1);
    localparam logic [7:0]  IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx_n;
    logic        step, wrap_n;
    // next state: load beats scan-off beats pause beats step beats count
    always_comb begin
        step   = !load && scan && en && cnt == LAST;
        idx_n  = load ? in : step ? idx + 3'd1 : idx;
        cnt_n  = (load || !scan || step) ? 16'd0 : !en ? cnt : cnt + 16'd1;
        wrap_n = step && idx == 3'd7;
    end
    // out is built from next-state idx so out and idx move on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= 3'd0;
            cnt  <= 16'd0;
            wrap <= 1'b0;
            out  <= IDLE;
        end else begin
            idx  <= idx_n;
            cnt  <= cnt_n;
            wrap <= wrap_n;
            out  <= en ? ((8'd1 << idx_n) ^ IDLE) : IDLE;
        end
    end
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed checks of load, scan, pause, wrap and async reset
module tb_onehot_scan_decoder;
    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, scan = 1'b0, load = 1'b0;
    logic [2:0] in = 3'd0;
    logic [7:0] out, out_al, out1;
    logic [2:0] idx, idx_al, idx1;
    logic wrap, wrap_al, wrap1;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    onehot_scan_decoder #(.DIV(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .load(load), .in(in),
        .out(out), .idx(idx), .wrap(wrap));
    onehot_scan_decoder #(.DIV(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .load(load), .in(in),
        .out(out_al), .idx(idx_al), .wrap(wrap_al));
    onehot_scan_decoder #(.DIV(1), .ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .scan(scan), .load(load), .in(in),
        .out(out1), .idx(idx1), .wrap(wrap1));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] oh;
        #1 rst_n = 1'b0;
        #1;
        check("rst idx", 8'(idx), 8'h00);
        check("rst out", out, 8'h00);
        check("rst wrap", 8'(wrap), 8'h00);
        check("rst out_al", out_al, 8'hFF);
        tick();
        tick();
        check("rst hold out", out, 8'h00);
        rst_n = 1'b1; en = 1'b1; scan = 1'b0;
        tick();
        check("en out", out, 8'h01);
        check("en idx", 8'(idx), 8'h00);
        load = 1'b1; in = 3'd5;
        tick();
        load = 1'b0; in = 3'd0;
        check("load5 idx", 8'(idx), 8'h05);
        check("load5 out", out, 8'h20);
        check("load5 out_al", out_al, 8'hDF);
        tick();
        check("load5 hold", out, 8'h20);
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; in = 3'(i);
            tick();
            oh = 8'h01 << i;
            check($sformatf("sweep%0d out", i), out, oh);
            check($sformatf("sweep%0d out_al", i), out_al, ~oh);
            check($sformatf("sweep%0d ones", i), 8'($countones(out)), 8'd1);
        end
        in = 3'd0;
        tick();
        load = 1'b0; scan = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            check($sformatf("scan4 idx k%0d", k), 8'(idx), 8'((k / 4) % 8));
            check($sformatf("scan4 wrap k%0d", k), 8'(wrap), 8'(k == 32));
            check($sformatf("scan1 out k%0d", k), out1, 8'h01 << (k % 8));
            check($sformatf("scan1 wrap k%0d", k), 8'(wrap1), 8'(k % 8 == 0));
        end
        for (int k = 0; k < 10; k++) tick();
        check("pre-pause idx", 8'(idx), 8'h02);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("pause out %0d", k), out, 8'h00);
            check($sformatf("pause idx %0d", k), 8'(idx), 8'h02);
        end
        en = 1'b1;
        tick();
        check("resume out", out, 8'h04);
        tick();
        check("resume step idx", 8'(idx), 8'h03);
        check("resume step out", out, 8'h08);
        for (int k = 0; k < 3; k++) tick();
        check("due idx", 8'(idx), 8'h03);
        load = 1'b1; in = 3'd7;
        tick();
        load = 1'b0; in = 3'd0;
        check("ld-vs-step idx", 8'(idx), 8'h07);
        check("ld-vs-step wrap", 8'(wrap), 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("after ld idx %0d", k), 8'(idx), 8'h07);
        end
        tick();
        check("ld7 wrap idx", 8'(idx), 8'h00);
        check("ld7 wrap", 8'(wrap), 8'h01);
        check("ld7 wrap out", out, 8'h01);
        tick();
        check("wrap clears", 8'(wrap), 8'h00);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async idx", 8'(idx), 8'h00);
        check("async out", out, 8'h00);
        check("async out_al", out_al, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("restart idx %0d", k), 8'(idx), 8'(k / 4));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Registered 3-to-8 one-hot decoder with built-in scan sequencer.
- Converts a 3-bit index into an 8-bit one-hot select: the inverse of the baseunits 8-to-3 encoder.
- Index is either loaded directly or auto-stepped 0..7 at a programmable rate.
- Drives digit-select lines for multiplexed 8-digit displays, or walking-LED / row-select strobes.

Parameters:
- DIV, 4, clock cycles spent on each index in scan mode; legal range 1..65535.
- ACTIVE_LOW, 0, output polarity: 0 = selected bit 1 and others 0; 1 = selected bit 0 and others 1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- en  input  1  output enable; 0 forces all outputs inactive and freezes scanning
- scan  input  1  1 = auto-step index every DIV cycles; 0 = hold index
- load  input  1  1 = load index from in on this edge
- in  input  3  index value to load
- out  output  8  registered one-hot (or one-cold) select
- idx  output  3  current index register
- wrap  output  1  one-cycle pulse when a scan step takes idx from 7 to 0

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. While rst_n=0:
  - idx=0, internal divider cnt=0, wrap=0.
  - out=8'h00 when ACTIVE_LOW=0; out=8'hFF when ACTIVE_LOW=1.
- Reset mid-scan abandons the divider count. After release, scanning restarts from idx 0 with a full DIV period.
- Divider cnt is 16 bits and counts 0..DIV-1.
- Per rising edge, evaluate in this priority order:
  1. load=1: idx<=in; cnt<=0; wrap<=0. Load is honoured even when en=0 or scan=1.
  2. Else if scan=0: idx holds; cnt<=0; wrap<=0.
  3. Else if en=0: idx and cnt hold; wrap<=0.
  4. Else if cnt==DIV-1: cnt<=0; idx<=idx+1 mod 8; wrap<=1 only if old idx==7.
  5. Else: cnt<=cnt+1; wrap<=0.
- out is registered from the next-state idx and en, so out and idx change on the same edge.
  - en=1: bit idx of out is active and all other bits are inactive. Exactly one bit is active.
  - en=0: all bits of out are inactive.
- Latency: one clock from sampling load/in or en to the corresponding change on out/idx. There is no combinational path from inputs to outputs.
- DIV=1: idx steps every enabled scan cycle and cnt stays 0.
- Scan timing: after scan rises with cnt=0, the first step occurs on the DIV-th enabled edge. Each index then occupies exactly DIV enabled cycles.
- Simultaneous load and scan step: load wins, no wrap pulse, and the next step comes a full DIV cycles later.
- Loading 7 then scanning: the subsequent step produces idx=0 with wrap=1.
- Toggling en mid-period pauses cnt without losing position. Re-enabling resumes the remaining count.
- in is sampled only when load=1. X on in while load=0 must not propagate.

Test Plan:
1. Reset with ACTIVE_LOW=0, DIV=4 -> idx=0, out=8'h00, wrap=0. Release, then en=1, scan=0 -> out=8'h01 after 1 edge.
2. load=1 with in=3'd5 for one cycle, en=1 -> next edge idx=5 and out=8'h20. With ACTIVE_LOW=1 -> out=8'hDF. Sweep in 0..7 and check exactly one active bit each time.
3. scan=1, en=1, DIV=4 from idx=0 -> idx changes every 4 edges through 0,1,...,7,0. wrap=1 for exactly the one cycle idx becomes 0. Total period 32 cycles.
4. DIV=1 scan -> idx increments every edge. wrap pulses every 8 cycles. out walks 01,02,04,...,80,01.
5. Scanning at idx=2, cnt=2: drop en for 3 cycles -> out=8'h00 and idx/cnt frozen. Restore en -> out=8'h04 for 1 more cycle, then idx=3.
6. Assert load with in=7 on the same edge a scan step is due -> idx=7, wrap=0, next step after 4 cycles gives idx=0 with wrap=1. Assert rst_n=0 asynchronously mid-scan -> outputs reset immediately, without waiting for clk.
